// File: rtl/sd_cmd_pkg.sv
// sd_cmd_pkg: shared types, constants and the CRC7 step function for the
// SD command-line engine.
//   resp_type_e    response format selected per command
//   state_e        engine FSM states
//   crc7_next()    one serial step of CRC7 (x^7 + x^3 + 1), MSB-first
package sd_cmd_pkg;

   typedef enum logic [1:0] {
      RESP_NONE      = 2'b00,
      RESP_R48       = 2'b01,
      RESP_R136      = 2'b10,
      RESP_R48_NOCRC = 2'b11
   } resp_type_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SEND = 3'd1,
      ST_WAIT = 3'd2,
      ST_RECV = 3'd3,
      ST_GAP  = 3'd4,
      ST_DONE = 3'd5
   } state_e;

   localparam int CMD_FRAME_BITS = 48;
   localparam int R48_BITS       = 48;
   localparam int R136_BITS      = 136;

   function automatic logic [6:0] crc7_next(input logic [6:0] crc, input logic b);
      logic fb;
      fb = b ^ crc[6];
      return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
   endfunction

endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: serial CRC7 accumulator, one bit per enabled cycle, MSB first.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   clr_i        restart the accumulator at 0 (wins over en_i)
//   en_i         fold bit_i into the CRC this cycle
//   bit_i        serial data bit
//   crc_o        current CRC7 value
module sd_crc7
   import sd_cmd_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr_i,
   input  logic       en_i,
   input  logic       bit_i,
   output logic [6:0] crc_o
);

   always_ff @(posedge clk) begin
      if (!rst_n)     crc_o <= 7'd0;
      else if (clr_i) crc_o <= 7'd0;
      else if (en_i)  crc_o <= crc7_next(crc_o, bit_i);
   end

endmodule

// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine: SD CMD-line engine. Sends a 48-bit command frame with CRC7
// on the drive strobes, then captures a 48/136-bit response on the sample
// strobes with timeout, end-bit and (optionally) CRC checking.
// Optional build macro: SD_CMD_RESP_CRC_CHK_EN enables the response CRC check;
// without it crc_err_o is tied 0.
// Ports:
//   PCLK_i, PRESETn_i            clock, synchronous active-low reset
//   sd_drv_stb_i, sd_smp_stb_i   SD clock falling / rising edge strobes
//   cmd_start_i, cmd_idx_i, cmd_arg_i, resp_type_i   command request
//   cmd_busy_o, cmd_done_o       status
//   resp_o                       captured response
//   timeout_err_o, crc_err_o, end_err_o   error flags, held until next accept
//   cmd_out_o, cmd_oe_o, cmd_in_i         CMD pad
module sd_cmd_engine
   import sd_cmd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int NCC_CYCLES     = 8
) (
   input  logic         PCLK_i,
   input  logic         PRESETn_i,
   input  logic         sd_drv_stb_i,
   input  logic         sd_smp_stb_i,
   input  logic         cmd_start_i,
   input  logic [5:0]   cmd_idx_i,
   input  logic [31:0]  cmd_arg_i,
   input  logic [1:0]   resp_type_i,
   output logic         cmd_busy_o,
   output logic         cmd_done_o,
   output logic [127:0] resp_o,
   output logic         timeout_err_o,
   output logic         crc_err_o,
   output logic         end_err_o,
   output logic         cmd_out_o,
   output logic         cmd_oe_o,
   input  logic         cmd_in_i
);

   state_e       state;
   resp_type_e   rtype;
   logic [15:0]  cnt;       // frame bit / wait strobe / received bit / gap strobe counter
   logic [39:0]  tx_sr;     // start, direction, idx, arg
   logic [126:0] rx_sr;
   logic [127:0] rx_next;
   logic [6:0]   tx_crc;
   logic [15:0]  last_idx;
   logic         accept, rx_last, tx_bit;

   assign accept   = (state == ST_IDLE) && cmd_start_i;
   assign rx_next  = {rx_sr, cmd_in_i};
   assign last_idx = (rtype == RESP_R136) ? 16'(R136_BITS - 1) : 16'(R48_BITS - 1);
   assign rx_last  = (state == ST_RECV) && sd_smp_stb_i && (cnt == last_idx);

   assign cmd_busy_o = (state != ST_IDLE) && (state != ST_DONE);
   assign cmd_done_o = (state == ST_DONE);

   // Frame bits 0..39 come from the shift register, 40..46 are the CRC
   // (cnt[2:0] runs 0..6 over that range), bit 47 is the end bit.
   always_comb begin
      tx_bit = 1'b1;
      if (cnt < 16'd40)                            tx_bit = tx_sr[39];
      else if (cnt < 16'(CMD_FRAME_BITS - 1))      tx_bit = tx_crc[3'd6 - cnt[2:0]];
   end

   sd_crc7 u_tx_crc (
      .clk   (PCLK_i),
      .rst_n (PRESETn_i),
      .clr_i (accept),
      .en_i  ((state == ST_SEND) && sd_drv_stb_i && (cnt < 16'd40)),
      .bit_i (tx_sr[39]),
      .crc_o (tx_crc)
   );

   always_ff @(posedge PCLK_i) begin
      if (!PRESETn_i) begin
         state         <= ST_IDLE;
         rtype         <= RESP_NONE;
         cnt           <= '0;
         tx_sr         <= '0;
         rx_sr         <= '0;
         resp_o        <= '0;
         timeout_err_o <= 1'b0;
         end_err_o     <= 1'b0;
         cmd_out_o     <= 1'b1;
         cmd_oe_o      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (cmd_start_i) begin
               rtype         <= resp_type_e'(resp_type_i);
               tx_sr         <= {2'b01, cmd_idx_i, cmd_arg_i};
               cnt           <= '0;
               timeout_err_o <= 1'b0;
               end_err_o     <= 1'b0;
               state         <= ST_SEND;
            end
            ST_SEND: if (sd_drv_stb_i) begin
               if (cnt < 16'(CMD_FRAME_BITS)) begin
                  cmd_oe_o  <= 1'b1;
                  cmd_out_o <= tx_bit;
                  cnt       <= cnt + 16'd1;
                  if (cnt < 16'd40) tx_sr <= {tx_sr[38:0], 1'b0};
               end else begin
                  // release the pad one drive strobe after the end bit
                  cmd_oe_o  <= 1'b0;
                  cmd_out_o <= 1'b1;
                  cnt       <= '0;
                  state     <= (rtype == RESP_NONE) ? ST_GAP : ST_WAIT;
               end
            end
            ST_WAIT: if (sd_smp_stb_i) begin
               if (!cmd_in_i) begin
                  rx_sr <= rx_next[126:0];
                  cnt   <= 16'd1;   // start bit is received bit 0
                  state <= ST_RECV;
               end else if (cnt + 16'd1 == 16'(TIMEOUT_CYCLES)) begin
                  timeout_err_o <= 1'b1;
                  cnt           <= '0;
                  state         <= ST_GAP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            ST_RECV: if (sd_smp_stb_i) begin
               rx_sr <= rx_next[126:0];
               cnt   <= cnt + 16'd1;
               if (rx_last) begin
                  end_err_o <= ~cmd_in_i;
                  resp_o    <= (rtype == RESP_R136) ? rx_next : {96'd0, rx_next[39:8]};
                  cnt       <= '0;
                  state     <= ST_GAP;
               end
            end
            ST_GAP: if (sd_drv_stb_i) begin
               if (cnt + 16'd1 == 16'(NCC_CYCLES)) begin
                  cnt   <= '0;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef SD_CMD_RESP_CRC_CHK_EN
   // R48 covers received bits 0..39 (start bit folded in while in WAIT);
   // R136 skips the 8 header bits and covers received bits 8..127.
   logic [6:0]  rx_crc;
   logic [15:0] crc_lo, crc_hi;
   logic        rx_crc_en, crc_bad;

   assign crc_lo    = (rtype == RESP_R136) ? 16'd8 : 16'd0;
   assign crc_hi    = last_idx - 16'd7;
   assign rx_crc_en = sd_smp_stb_i &&
                      (((state == ST_WAIT) && !cmd_in_i && (rtype != RESP_R136)) ||
                       ((state == ST_RECV) && (cnt >= crc_lo) && (cnt < crc_hi)));

   sd_crc7 u_rx_crc (
      .clk   (PCLK_i),
      .rst_n (PRESETn_i),
      .clr_i (accept),
      .en_i  (rx_crc_en),
      .bit_i (cmd_in_i),
      .crc_o (rx_crc)
   );

   // mismatch is latched at the last bit and published at DONE
   always_ff @(posedge PCLK_i) begin
      if (!PRESETn_i) begin
         crc_bad   <= 1'b0;
         crc_err_o <= 1'b0;
      end else if (accept) begin
         crc_bad   <= 1'b0;
         crc_err_o <= 1'b0;
      end else if (rx_last) begin
         crc_bad <= ((rtype == RESP_R48) || (rtype == RESP_R136)) && (rx_crc != rx_next[7:1]);
      end else if (state == ST_DONE) begin
         crc_err_o <= crc_bad;
      end
   end
`else
   assign crc_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sd_cmd_engine.sv
// tb_sd_cmd_engine: directed bench for sd_cmd_engine. One SD clock period is
// four PCLK cycles: drive strobe, idle, sample strobe, idle. The bench acts
// as the card, capturing the TX frame and replaying a response.
module tb_sd_cmd_engine;

   logic         clk = 1'b0;
   logic         rst_n, drv, smp, start, cmd_in;
   logic [5:0]   idx;
   logic [31:0]  arg;
   logic [1:0]   rtype;
   logic         busy, done, tmo, crc_err, end_err, cmd_out, cmd_oe;
   logic [127:0] resp;

   always #5 clk = ~clk;

   sd_cmd_engine dut (
      .PCLK_i(clk), .PRESETn_i(rst_n),
      .sd_drv_stb_i(drv), .sd_smp_stb_i(smp),
      .cmd_start_i(start), .cmd_idx_i(idx), .cmd_arg_i(arg), .resp_type_i(rtype),
      .cmd_busy_o(busy), .cmd_done_o(done), .resp_o(resp),
      .timeout_err_o(tmo), .crc_err_o(crc_err), .end_err_o(end_err),
      .cmd_out_o(cmd_out), .cmd_oe_o(cmd_oe), .cmd_in_i(cmd_in)
   );

   int n_chk = 0, n_pass = 0;
   logic [47:0] tx;
   int ntx, ndrv, ndrv_done;
   logic done_seen, busy_acc;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   function automatic logic [6:0] crc7_120(input logic [119:0] d);
      logic [6:0] c;
      logic fb;
      c = 7'd0;
      for (int i = 119; i >= 0; i--) begin
         fb = d[i] ^ c[6];
         c = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   task automatic note_done();
      if (done && !done_seen) begin
         done_seen = 1'b1;
         ndrv_done = ndrv;
      end
   endtask

   // Issues one command and plays the card: after the pad is released it
   // holds CMD high for dly samples, then shifts out rlen response bits.
   task automatic run_txn(input logic [5:0] i, input logic [31:0] a, input logic [1:0] t,
                          input logic [135:0] rsp, input int rlen, input int dly, input int glitch);
      int bi, ns;
      logic oe_q, rel;
      tx = '0; ntx = 0; ndrv = 0; ndrv_done = -1; done_seen = 1'b0;
      bi = 0; ns = 0; oe_q = 1'b0; rel = 1'b0;
      @(negedge clk);
      idx = i; arg = a; rtype = t; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      busy_acc = busy;
      for (int p = 0; p < 300 && !done_seen; p++) begin
         if (p == glitch) begin start = 1'b1; idx = ~i; arg = ~a; end
         drv = 1'b1;
         @(negedge clk);
         drv = 1'b0; start = 1'b0; ndrv++;
         if (cmd_oe) begin tx = {tx[46:0], cmd_out}; ntx++; end
         if (oe_q && !cmd_oe) rel = 1'b1;
         oe_q = cmd_oe;
         note_done();
         @(negedge clk);
         note_done();
         if (rel && ns >= dly && bi < rlen) begin cmd_in = rsp[rlen-1-bi]; bi++; end
         else cmd_in = 1'b1;
         if (rel) ns++;
         smp = 1'b1;
         @(negedge clk);
         smp = 1'b0;
         note_done();
         @(negedge clk);
         note_done();
      end
      cmd_in = 1'b1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [119:0] aa;
   logic [6:0]   crc136;
   logic         exp_crc3;

   initial begin
      rst_n = 1'b0; drv = 1'b0; smp = 1'b0; start = 1'b0; cmd_in = 1'b1;
      idx = '0; arg = '0; rtype = '0;
      repeat (3) @(negedge clk);
      chk("rst_out",  128'(cmd_out), 128'd1);
      chk("rst_oe",   128'(cmd_oe),  128'd0);
      chk("rst_busy", 128'(busy),    128'd0);
      chk("rst_done", 128'(done),    128'd0);
      chk("rst_tmo",  128'(tmo),     128'd0);
      chk("rst_crc",  128'(crc_err), 128'd0);
      chk("rst_end",  128'(end_err), 128'd0);
      chk("rst_resp", resp,          128'd0);
      rst_n = 1'b1;

      // CMD0, no response
      run_txn(6'd0, 32'd0, 2'b00, 136'd0, 0, 0, -1);
      chk("cmd0_busy", 128'(busy_acc),  128'd1);
      chk("cmd0_tx",   128'(tx),        128'h400000000095);
      chk("cmd0_ntx",  128'(ntx),       128'd48);
      chk("cmd0_ndrv", 128'(ndrv_done), 128'd57);
      chk("cmd0_errs", 128'({tmo, crc_err, end_err}), 128'd0);

      // CMD8 with a good R7 reply
      run_txn(6'd8, 32'h1AA, 2'b01, 136'h08000001AA13, 48, 2, -1);
      chk("cmd8_tx",   128'(tx),        128'h48000001AA87);
      chk("cmd8_resp", resp,            128'h1AA);
      chk("cmd8_ndrv", 128'(ndrv_done), 128'd106);
      chk("cmd8_errs", 128'({tmo, crc_err, end_err}), 128'd0);

      // same reply, corrupted CRC
`ifdef SD_CMD_RESP_CRC_CHK_EN
      exp_crc3 = 1'b1;
`else
      exp_crc3 = 1'b0;
`endif
      run_txn(6'd8, 32'h1AA, 2'b01, 136'h08000001AA15, 48, 2, -1);
      chk("badcrc_crc",  128'(crc_err), 128'(exp_crc3));
      chk("badcrc_resp", resp,          128'h1AA);
      chk("badcrc_end",  128'(end_err), 128'd0);

      // R3 reply: CRC field is all ones and must not be checked
      run_txn(6'd41, 32'h0, 2'b11, 136'h3F00FF8000FF, 48, 1, -1);
      chk("r3_resp", resp,            128'h00FF8000);
      chk("r3_crc",  128'(crc_err),   128'd0);
      chk("r3_end",  128'(end_err),   128'd0);

      // no card reply after a fresh reset
      do_reset();
      run_txn(6'd8, 32'h1AA, 2'b01, 136'd0, 0, 0, -1);
      chk("tmo_flag", 128'(tmo),       128'd1);
      chk("tmo_done", 128'(done_seen), 128'd1);
      chk("tmo_ndrv", 128'(ndrv_done), 128'd120);
      chk("tmo_resp", resp,            128'd0);

      // R136, good then bad end bit
      aa = {15{8'hAA}};
      crc136 = crc7_120(aa);
      run_txn(6'd2, 32'h0, 2'b10, {8'h3F, aa, crc136, 1'b1}, 136, 0, -1);
      chk("r136_resp", resp, {aa, crc136, 1'b1});
      chk("r136_errs", 128'({tmo, crc_err, end_err}), 128'd0);
      chk("r136_ndrv", 128'(ndrv_done), 128'd192);
      run_txn(6'd2, 32'h0, 2'b10, {8'h3F, aa, crc136, 1'b0}, 136, 0, -1);
      chk("r136e_end",  128'(end_err), 128'd1);
      chk("r136e_crc",  128'(crc_err), 128'd0);
      chk("r136e_resp", resp, {aa, crc136, 1'b0});

      // start pulsed mid-SEND is ignored
      run_txn(6'd0, 32'd0, 2'b00, 136'd0, 0, 0, 10);
      chk("glitch_tx",   128'(tx),        128'h400000000095);
      chk("glitch_ndrv", 128'(ndrv_done), 128'd57);

      // reset during SEND
      @(negedge clk);
      idx = 6'd17; arg = 32'h12345678; rtype = 2'b01; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) begin drv = 1'b1; @(negedge clk); drv = 1'b0; @(negedge clk); end
      chk("abort_oe_pre", 128'(cmd_oe), 128'd1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_oe",   128'(cmd_oe),  128'd0);
      chk("abort_out",  128'(cmd_out), 128'd1);
      chk("abort_busy", 128'(busy),    128'd0);
      chk("abort_done", 128'(done),    128'd0);
      rst_n = 1'b1;
      done_seen = 1'b0;
      repeat (40) begin
         drv = 1'b1; @(negedge clk); drv = 1'b0;
         if (done) done_seen = 1'b1;
         smp = 1'b1; @(negedge clk); smp = 1'b0;
         if (done) done_seen = 1'b1;
      end
      chk("abort_nodone", 128'(done_seen), 128'd0);
      chk("abort_idle",   128'({busy, cmd_oe}), 128'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
